replacement_controller: RTL
===========================

// Module: replacement_controller
// PURPOSE
//  Initiator side of the per-set LRU interface. Accepts one lookup outcome (hit/miss) per request and drives
//  lru_set/lru_selected_way/lru_process. On a miss it chooses a victim (first invalid way, else LRU victim),
//  sequences writeback (if dirty) and fill, then promotes the filled way to MRU. Sits between the cache
//  controller FSM and the LRU counter array; owns per-set/way valid and dirty bits.
// PARAMETERS
//  NUM_SETS  1  number of cache sets; SET_SIZE = $clog2(NUM_SETS), min width 1
//  ASSOC     2  ways per set; must be >1 and even (elaboration $error otherwise)
// PORTS
//  clk               in   1          clock
//  reset             in   1          synchronous, active-high
//  req_valid         in   1          lookup outcome offered
//  req_ready         out  1          controller can accept (state IDLE)
//  req_set           in   SET_SIZE   set index of lookup
//  req_hit           in   1          1 = tag hit in req_way
//  req_way           in   ASSOC_SIZE hit way (ignored on miss)
//  req_write         in   1          access is a store (sets dirty on final way)
//  wb_req            out  1          writeback of wb_way in lru_set requested; held until wb_done
//  wb_way            out  ASSOC_SIZE way being written back
//  wb_done           in   1          writeback complete (single-cycle pulse)
//  fill_req          out  1          fill of fill_way requested; held until fill_done
//  fill_way          out  ASSOC_SIZE way being filled
//  fill_done         in   1          fill complete (single-cycle pulse)
//  lru_set           out  SET_SIZE   set presented to LRU counters (registered req_set)
//  lru_selected_way  out  ASSOC_SIZE way to promote to MRU
//  lru_process       out  1          one-cycle pulse: apply MRU update
//  lru_victim_way    in   ASSOC_SIZE LRU victim for lru_set (combinational from counters)
//  resp_valid        out  1          one-cycle pulse: request finished
//  resp_way          out  ASSOC_SIZE way now holding the line (valid with resp_valid)
// BEHAVIOUR
//  - Reset: state IDLE; all valid/dirty bits 0; req_ready=1; wb_req, fill_req, lru_process, resp_valid = 0;
//    lru_set, lru_selected_way, wb_way, fill_way, resp_way = 0. Reset mid-operation aborts immediately, no pulse.
//  - States: IDLE, SELECT, WRITEBACK, FILL, PROMOTE.
//  - IDLE: req_ready=1. On req_valid, register set/hit/way/write into lru_set etc.
//    hit -> PROMOTE (way=req_way); miss -> SELECT.
//  - SELECT (1 cycle): lru_set stable; victim = lowest-index way with valid==0, else lru_victim_way.
//    victim valid&dirty -> WRITEBACK, else -> FILL. wb_way/fill_way load victim here.
//  - WRITEBACK: wb_req=1 until wb_done; on wb_done clear dirty[set][victim], wb_req=0 same edge -> FILL.
//  - FILL: fill_req=1 until fill_done; on fill_done set valid[set][victim], dirty = req_write -> PROMOTE.
//  - PROMOTE (1 cycle): lru_process=1, lru_selected_way=final way, resp_valid=1, resp_way=final way;
//    on a hit with req_write, dirty[set][way] set this cycle. Next -> IDLE.
//  - Latency: hit 2 cycles accept->resp_valid; clean miss 3 + fill wait; dirty miss adds writeback wait.
//  - Exactly one lru_process pulse per accepted request; never pulsed outside PROMOTE.
//  - Hit on a way with valid==0 is a protocol error: assert; way is still promoted, valid bits untouched.
//  - wb_done/fill_done outside their states are ignored (assert they never occur).
//  - req_valid while !req_ready is ignored; requester holds the request stable until accepted.
//  - Back-to-back: IDLE accepts the next request the cycle after PROMOTE; no bubble beyond that.
// STRUCTURE
//  - cache_pkg: typedef enum repl_state_e {IDLE,SELECT,WRITEBACK,FILL,PROMOTE}; SET_SIZE/ASSOC_SIZE helper fns.
//  - Sub-module first_zero_finder #(WIDTH=ASSOC): valid vector -> {found, lowest zero index}.
//  - Valid/dirty: logic [NUM_SETS-1:0][ASSOC-1:0] arrays, written only in FILL/WRITEBACK/PROMOTE.
// TESTING
//  - After reset, miss set 0 x4 (ASSOC=4, fills immediate) -> fill_way 0,1,2,3 in order; one lru_process per request.
//  - Set 0 full and clean, miss -> fill_way == lru_victim_way (way 0 after promotions 0..3); no wb_req.
//  - Write hit way 2 set 1, then miss evicting way 2 -> wb_req with wb_way=2 before fill_req; dirty cleared.
//  - Hit set 3 way 1 -> resp_valid 2 cycles after accept, lru_set=3, lru_selected_way=1, lru_process 1 cycle.
//  - Reset asserted while in FILL -> next cycle IDLE, fill_req=0, no resp_valid, all valid bits 0.
//  - Spurious fill_done in IDLE and req_valid while busy -> no state change, assertion fires for the fill_done.

Source files
------------

// File: rtl/replacement_controller_pkg.sv
// Shared types and width helpers for the cache replacement controller.
// Holds the controller state encoding and the set/way index width functions.
// Imported by the controller top and usable by any block that sizes set/way indices.
package replacement_controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        WRITEBACK,
        FILL,
        PROMOTE
    } repl_state_e;

    // A single-set cache still carries a 1-bit set index so ports never collapse to zero width.
    function automatic int set_size(input int num_sets);
        return (num_sets > 1) ? $clog2(num_sets) : 1;
    endfunction

    function automatic int assoc_size(input int assoc);
        return (assoc > 1) ? $clog2(assoc) : 1;
    endfunction

endpackage

// File: rtl/first_zero_finder.sv
// Finds the lowest-index clear bit in a vector (used to pick the first invalid way).
// Ports: vec_i = per-way valid bits; found_o = some bit is clear; idx_o = lowest clear index.
// Purely combinational; idx_o is 0 when found_o is low.
module first_zero_finder #(
    parameter  int WIDTH = 2,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top down so the last hit, i.e. the lowest index, wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!vec_i[i]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/replacement_controller.sv
// Replacement controller: takes one hit/miss lookup outcome per request, picks a victim on a miss
// (first invalid way, else the LRU victim), sequences writeback/fill and promotes the final way to MRU.
// Owns the per-set/way valid and dirty bits.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   req_valid/req_ready                lookup handshake (ready only in IDLE)
//   req_set/req_hit/req_way/req_write  lookup outcome
//   wb_req/wb_way/wb_done              writeback request, held until wb_done pulse
//   fill_req/fill_way/fill_done        fill request, held until fill_done pulse
//   lru_set/lru_selected_way/lru_process  MRU update towards the LRU counter array
//   lru_victim_way                     LRU victim of lru_set from the counter array
//   resp_valid/resp_way                one-cycle completion pulse and the way holding the line
// Latency, counting the accept cycle: hit 2 cycles, clean miss 3 + fill cycles, dirty miss adds wb cycles.
module replacement_controller
    import replacement_controller_pkg::*;
#(
    parameter  int NUM_SETS   = 1,
    parameter  int ASSOC      = 2,
    localparam int SET_SIZE   = set_size(NUM_SETS),
    localparam int ASSOC_SIZE = assoc_size(ASSOC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SET_SIZE-1:0]   req_set,
    input  logic                  req_hit,
    input  logic [ASSOC_SIZE-1:0] req_way,
    input  logic                  req_write,
    output logic                  wb_req,
    output logic [ASSOC_SIZE-1:0] wb_way,
    input  logic                  wb_done,
    output logic                  fill_req,
    output logic [ASSOC_SIZE-1:0] fill_way,
    input  logic                  fill_done,
    output logic [SET_SIZE-1:0]   lru_set,
    output logic [ASSOC_SIZE-1:0] lru_selected_way,
    output logic                  lru_process,
    input  logic [ASSOC_SIZE-1:0] lru_victim_way,
    output logic                  resp_valid,
    output logic [ASSOC_SIZE-1:0] resp_way
);

    if (ASSOC < 2 || (ASSOC % 2) != 0) begin : g_assoc_check
        $error("replacement_controller: ASSOC must be greater than 1 and even");
    end

    repl_state_e                        state_q, state_d;
    logic [SET_SIZE-1:0]                set_q, set_d;
    logic                               hit_q, hit_d;
    logic                               write_q, write_d;
    logic [ASSOC_SIZE-1:0]              way_q, way_d;
    logic [ASSOC_SIZE-1:0]              wb_way_q, wb_way_d;
    logic [ASSOC_SIZE-1:0]              fill_way_q, fill_way_d;
    logic [NUM_SETS-1:0][ASSOC-1:0]     valid_q, valid_d;
    logic [NUM_SETS-1:0][ASSOC-1:0]     dirty_q, dirty_d;

    logic                               free_found;
    logic [ASSOC_SIZE-1:0]              free_way;
    logic [ASSOC_SIZE-1:0]              victim_way;

    first_zero_finder #(
        .WIDTH (ASSOC)
    ) u_free_way (
        .vec_i   (valid_q[set_q]),
        .found_o (free_found),
        .idx_o   (free_way)
    );

    // An empty way is always preferred over evicting a live line.
    assign victim_way = free_found ? free_way : lru_victim_way;

    assign lru_set          = set_q;
    assign lru_selected_way = way_q;
    assign resp_way         = way_q;
    assign wb_way           = wb_way_q;
    assign fill_way         = fill_way_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            set_q      <= '0;
            hit_q      <= 1'b0;
            write_q    <= 1'b0;
            way_q      <= '0;
            wb_way_q   <= '0;
            fill_way_q <= '0;
            valid_q    <= '0;
            dirty_q    <= '0;
        end else begin
            state_q    <= state_d;
            set_q      <= set_d;
            hit_q      <= hit_d;
            write_q    <= write_d;
            way_q      <= way_d;
            wb_way_q   <= wb_way_d;
            fill_way_q <= fill_way_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        set_d       = set_q;
        hit_d       = hit_q;
        write_d     = write_q;
        way_d       = way_q;
        wb_way_d    = wb_way_q;
        fill_way_d  = fill_way_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        req_ready   = 1'b0;
        wb_req      = 1'b0;
        fill_req    = 1'b0;
        lru_process = 1'b0;
        resp_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    set_d   = req_set;
                    hit_d   = req_hit;
                    write_d = req_write;
                    if (req_hit) begin
                        way_d   = req_way;
                        state_d = PROMOTE;
                    end else begin
                        state_d = SELECT;
                    end
                end
            end

            SELECT: begin
                way_d      = victim_way;
                wb_way_d   = victim_way;
                fill_way_d = victim_way;
                if (valid_q[set_q][victim_way] && dirty_q[set_q][victim_way]) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = FILL;
                end
            end

            WRITEBACK: begin
                wb_req = 1'b1;
                if (wb_done) begin
                    dirty_d[set_q][wb_way_q] = 1'b0;
                    state_d                  = FILL;
                end
            end

            FILL: begin
                fill_req = 1'b1;
                if (fill_done) begin
                    valid_d[set_q][fill_way_q] = 1'b1;
                    dirty_d[set_q][fill_way_q] = write_q;
                    state_d                    = PROMOTE;
                end
            end

            PROMOTE: begin
                lru_process = 1'b1;
                resp_valid  = 1'b1;
                // A missing store already marked the line dirty when the fill landed.
                if (hit_q && write_q) begin
                    dirty_d[set_q][way_q] = 1'b1;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Protocol monitors: violations are reported but the datapath tolerates them.
    always @(posedge clk) begin
        if (!reset) begin
            if (state_q != WRITEBACK) begin
                assert (!wb_done)
                    else $warning("replacement_controller: wb_done outside WRITEBACK ignored");
            end
            if (state_q != FILL) begin
                assert (!fill_done)
                    else $warning("replacement_controller: fill_done outside FILL ignored");
            end
            if (state_q == IDLE && req_valid && req_hit) begin
                assert (valid_q[req_set][req_way])
                    else $warning("replacement_controller: hit reported on an invalid way");
            end
        end
    end

endmodule
